// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with a valid/ready request and result handshake.
//
// Bitwise, arithmetic and compare operations complete in one cycle. Shifts
// run one bit position per cycle through an internal shift register, so a
// shift by k takes k cycles before the result is presented.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request present on A/B/ctrl
//   in_ready   : block is idle and will take a request this cycle
//   A, B       : operands; B[SHW-1:0] is the shift amount for SLL/SRL
//   ctrl       : 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT (signed),
//                110 SLL, 111 SRL
//   out_valid  : Y and the flags hold a result
//   out_ready  : consumer takes the result this cycle
//   Y          : result
//   zero       : Y == 0
//   carry      : ADD carry-out; SUB no-borrow (A >= B unsigned); else 0
//   overflow   : signed overflow for ADD/SUB; else 0
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Shift engine: working value, direction and remaining step count.
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             sh_left_q, sh_left_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    // Result registers; they keep the last result across handshakes.
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sh_step;

    // Single-cycle datapath
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             slt;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             alu_v;

    assign accept   = in_valid && in_ready;
    assign is_shift = ctrl[2] & ctrl[1];
    assign shamt    = B[SHW-1:0];
    assign sh_step  = sh_left_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    // ADD/SUB are computed one bit wider so the top bit gives carry/borrow.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign slt  = $signed(A) < $signed(B);

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (ctrl)
            OP_AND: alu_y = A & B;
            OP_OR:  alu_y = A | B;
            OP_XOR: alu_y = A ^ B;
            OP_ADD: begin
                alu_y = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                // Same-sign operands producing an opposite-sign result.
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y = diff[WIDTH-1:0];
                // Top bit of the wide difference is the borrow.
                alu_c = ~diff[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, slt};
            default: alu_y = '0;
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // A zero-length shift finishes like any one-cycle op.
                    state_d = (is_shift && (shamt != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is gated by rst so nothing is taken during a reset cycle.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    // ------------------------------------------------------------ datapath
    always_comb begin
        sh_d      = sh_q;
        sh_left_d = sh_left_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift) begin
                        sh_d      = A;
                        sh_left_d = (ctrl == OP_SLL);
                        cnt_d     = shamt;
                        if (shamt == '0) begin
                            y_d     = A;
                            zero_d  = (A == '0);
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                        end
                    end else begin
                        y_d     = alu_y;
                        zero_d  = (alu_y == '0);
                        carry_d = alu_c;
                        ovf_d   = alu_v;
                    end
                end
            end
            SHIFT: begin
                sh_d  = sh_step;
                cnt_d = cnt_q - SHW'(1);
                // Y is only updated on the final step so the previous result
                // stays visible while the shift is in progress.
                if (cnt_q == SHW'(1)) begin
                    y_d     = sh_step;
                    zero_d  = (sh_step == '0);
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q      <= '0;
            sh_left_q <= 1'b0;
            cnt_q     <= '0;
            y_q       <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            sh_left_q <= sh_left_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Y        = y_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq (WIDTH=32 and WIDTH=8 instances).
// Drivers push the expected result (value, flags, due cycle) when a request is
// accepted; monitors pop and compare whenever the DUT presents a result.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    typedef struct {
        logic [63:0] y;
        bit          z;
        bit          c;
        bit          o;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, Y;
    logic [2:0]  ctrl;
    logic        zero, carry, overflow;

    // 8-bit instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, y8;
    logic [2:0]  ctrl8;
    logic        zero8, carry8, ovf8;

    alu_seq #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .zero(zero), .carry(carry), .overflow(overflow)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8),
        .Y(y8), .zero(zero8), .carry(carry8), .overflow(ovf8)
    );

    exp_t q[$];
    exp_t q8[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 0;
    bit   done8 = 0;
    bit   first = 1;
    int   ordy_mode = 0;   // 0: out_ready high, 1: random, 2: held low
    logic [31:0] last_y = '0;
    logic [2:0]  last_f = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: operation semantics with plain integer arithmetic.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] op, input int w);
        exp_t        e;
        longint unsigned mask, ua, ub, r;
        longint      sa, sb, smin, smax, sr;
        int          sh;
        mask = (64'd1 << w) - 1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = (ua >= (64'd1 << (w - 1))) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = (ub >= (64'd1 << (w - 1))) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        smin = -(longint'(1) << (w - 1));
        smax = (longint'(1) << (w - 1)) - 1;
        sh   = int'(ub % w);
        e.c = 0; e.o = 0; e.due = 0; r = 0;
        case (op)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd2: r = ua ^ ub;
            3'd3: begin
                r   = ua + ub;
                e.c = (r > mask);
                sr  = sa + sb;
                e.o = (sr > smax) || (sr < smin);
            end
            3'd4: begin
                r   = ua - ub;
                e.c = (ua >= ub);
                sr  = sa - sb;
                e.o = (sr > smax) || (sr < smin);
            end
            3'd5: r = (sa < sb) ? 1 : 0;
            3'd6: begin r = ua << sh; e.due = sh; end
            default: begin r = ua >> sh; e.due = sh; end
        endcase
        e.y = r & mask;
        e.z = (e.y == 0);
        return e;
    endfunction

    // One cycle of 32-bit stimulus; acc reports an accepted request.
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, output bit acc);
        exp_t e;
        @(posedge clk); #1;
        in_valid = v; A = a; B = b; ctrl = op;
        out_ready = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 1) ? 1'($urandom) : 1'b0;
        @(negedge clk);
        chk("in_ready", in_ready, (!rst && q.size() == 0));
        acc = v && in_ready;
        if (acc) begin
            e = model(a, b, op, 32);
            e.due += cyc + 1;
            q.push_back(e);
            $display("issue op=%0d A=%h B=%h expect Y=%h z%0d c%0d v%0d at cycle %0d",
                     op, a, b, e.y[31:0], e.z, e.c, e.o, e.due);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bit acc = 0;
        for (int i = 0; i < 100 && !acc; i++) drive(1'b1, a, b, op, acc);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit acc;
        for (int i = 0; i < 200 && q.size() != 0; i++)
            drive(1'b0, $urandom, $urandom, 3'($urandom), acc);
        if (q.size() != 0) chk("idle_timeout", q.size(), 0);
    endtask

    // Main driver
    initial begin
        bit acc;
        rst = 1; in_valid = 0; A = 0; B = 0; ctrl = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Y", Y, 0);
        chk("rst_flags", {zero, carry, overflow}, 0);
        chk("rst_Y8", {out_valid8, y8}, 0);
        mon_en = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        ordy_mode = 0;
        send(32'hFFFF0000, 32'h0F0F0F0F, 3'b000); wait_idle();
        send(32'hFFFFFFFF, 32'h00000001, 3'b011); wait_idle();
        send(32'h80000000, 32'h00000001, 3'b100); wait_idle();
        send(32'h00000001, 32'd5,        3'b110); wait_idle();
        send(32'h12345678, 32'd0,        3'b111); wait_idle();
        send(32'h00000005, 32'h00000005, 3'b100); wait_idle();
        send(32'h7FFFFFFF, 32'h00000001, 3'b011); wait_idle();
        send(32'hFFFFFFFF, 32'h00000001, 3'b101); wait_idle();

        // Result held with out_ready low, then released.
        ordy_mode = 2;
        send(32'h00F000F0, 32'h0F000F00, 3'b001);
        repeat (4) drive(1'b0, $urandom, $urandom, 3'($urandom), acc);
        ordy_mode = 0;
        wait_idle();

        // Random traffic; requests during busy cycles must be ignored.
        ordy_mode = 1;
        for (int i = 0; i < 1500; i++)
            drive(($urandom % 3) == 0, $urandom, $urandom, 3'($urandom), acc);
        ordy_mode = 0;
        wait_idle();

        for (int i = 0; i < 500 && !done8; i++) @(posedge clk);
        chk("dut8_done", done8, 1);

        // Reset in the 10th cycle of a 31-step shift aborts it.
        send(32'h80000000, 32'd31, 3'b111);
        repeat (9) drive(1'b0, $urandom, $urandom, 3'($urandom), acc);
        @(posedge clk); #1 rst = 1; in_valid = 0;
        @(negedge clk);
        chk("in_ready_during_rst", in_ready, 0);
        @(posedge clk); #1 rst = 0;
        q.delete(); first = 1; last_y = '0; last_f = '0;
        @(negedge clk);
        chk("in_ready_after_abort", in_ready, 1);
        chk("abort_outputs", {out_valid, Y, zero, carry, overflow}, 0);
        repeat (40) drive(1'b0, $urandom, $urandom, 3'($urandom), acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // 32-bit monitor
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk); #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (first) begin
                        chk("latency", cyc, q[0].due);
                        first = 0;
                    end
                    chk("Y", Y, q[0].y[31:0]);
                    chk("flags", {zero, carry, overflow}, {q[0].z, q[0].c, q[0].o});
                    if (out_ready) begin
                        $display("result Y=%h z%0d c%0d v%0d at cycle %0d",
                                 Y, zero, carry, overflow, cyc);
                        last_y = q[0].y[31:0];
                        last_f = {q[0].z, q[0].c, q[0].o};
                        void'(q.pop_front());
                        first = 1;
                    end
                end
            end else begin
                chk("Y_hold", Y, last_y);
                chk("flags_hold", {zero, carry, overflow}, last_f);
                if (q.size() != 0 && cyc > q[0].due) begin
                    chk("result_timeout", cyc, q[0].due);
                    void'(q.pop_front());
                    first = 1;
                end
            end
        end
    end

    // 8-bit driver
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        @(posedge clk); #1;
        in_valid8 = 1; a8 = a; b8 = b; ctrl8 = op;
        @(negedge clk);
        chk("in_ready8", in_ready8, 1);
        if (in_ready8) begin
            e = model({56'd0, a}, {56'd0, b}, op, 8);
            e.due += cyc + 1;
            q8.push_back(e);
            $display("issue8 op=%0d A=%h B=%h expect Y=%h at cycle %0d", op, a, b, e.y[7:0], e.due);
        end
        @(posedge clk); #1;
        in_valid8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) chk("idle8_timeout", q8.size(), 0);
    endtask

    initial begin
        in_valid8 = 0; a8 = 0; b8 = 0; ctrl8 = 0; out_ready8 = 1;
        wait (mon_en);
        @(negedge clk);
        while (rst) @(negedge clk);
        send8(8'h80, 8'h01, 3'b101);
        send8(8'hA5, 8'h5A, 3'b010);
        send8(8'h7F, 8'h01, 3'b011);
        send8(8'h81, 8'd7,  3'b111);
        for (int i = 0; i < 20; i++) send8(8'($urandom), 8'($urandom), 3'($urandom));
        done8 = 1;
    end

    // 8-bit monitor (out_ready8 is always high, so every valid cycle is new)
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk); #1;
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_out_valid8", out_valid8, 0);
                end else begin
                    chk("latency8", cyc, q8[0].due);
                    chk("Y8", y8, q8[0].y[7:0]);
                    chk("flags8", {zero8, carry8, ovf8}, {q8[0].z, q8[0].c, q8[0].o});
                    $display("result8 Y=%h z%0d c%0d v%0d at cycle %0d", y8, zero8, carry8, ovf8, cyc);
                    void'(q8.pop_front());
                end
            end
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are powers of two, 4..64.
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH), meaning the shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for shifts.
REQ-009 SHALL have port ctrl  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT (signed), 110 SLL, 111 SRL. Codes 000/001 keep the 1-bit AND/OR encoding.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Y  output  WIDTH  result.
REQ-013 SHALL have port zero  output  1  Y == 0.
REQ-014 SHALL have port carry  output  1  ADD carry-out; for SUB, 1 when A >= B unsigned (no borrow); 0 otherwise.
REQ-015 SHALL have port overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.

Function
REQ-016 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE with rst low.
REQ-018 SHALL accept a request when in_valid && in_ready, latching A, B and ctrl; later input changes SHALL NOT affect the result.
REQ-019 SHALL, for ctrl 000-101 accepted in cycle N, register Y and flags and go to DONE, with out_valid = 1 in cycle N+1.
REQ-020 SHALL, for SLL/SRL, go to SHIFT with counter = B[SHW-1:0] and shift the latched A by one bit per cycle (zero fill); once the counter reaches 0 it goes to DONE, with out_valid in cycle N+1+shamt.
REQ-021 SHALL treat a shift amount of 0 like a single-cycle op: go directly to DONE with Y = A and out_valid in cycle N+1.
REQ-022 SHALL compute ADD/SUB at WIDTH+1 bits; Y is the low WIDTH bits, and the result wraps modulo 2^WIDTH.
REQ-023 SHALL compute SLT as Y = {WIDTH-1 zeros, (signed A < signed B)}.
REQ-024 SHALL compute zero from the final Y in every op.
REQ-025 SHALL hold Y, flags and out_valid stable in DONE while out_ready = 0.
REQ-026 SHALL, in DONE with out_ready = 1, clear out_valid and return to IDLE next cycle, with in_ready = 1 in that cycle.
REQ-027 SHALL ignore in_valid outside IDLE; there is no queueing and no dropped-request flag.
REQ-028 SHALL keep Y, zero, carry and overflow at their last values after a handshake until the next result is registered.

Reset
REQ-029 SHALL, when rst is high at a clock edge, set state IDLE, out_valid 0, Y 0, zero 0, carry 0, overflow 0 and the shift counter 0.
REQ-030 SHALL drive in_ready = 0 while rst is high, and 1 in the first cycle after rst falls.
REQ-031 SHALL, on reset asserted in SHIFT or DONE, abort the operation; the aborted result never appears with out_valid = 1.

Verification
REQ-032 SHALL cover: AND, A=FFFF0000, B=0F0F0F0F, accepted cycle N -> Y=0F0F0000, zero=0, out_valid in N+1.
REQ-033 SHALL cover: ADD, A=FFFFFFFF, B=00000001 -> Y=00000000, zero=1, carry=1, overflow=0. Also SUB, A=80000000, B=00000001 -> Y=7FFFFFFF, carry=1, overflow=1.
REQ-034 SHALL cover: SLL, A=00000001, B=5 -> Y=00000020, out_valid in N+6, in_ready=0 in N+1..N+6. Also SRL with B=0 -> Y=A in N+1.
REQ-035 SHALL cover: OR result with out_ready held 0 for 3 cycles -> Y/out_valid stable and in_ready=0. Then out_ready=1 -> out_valid=0 and in_ready=1 in the next cycle.
REQ-036 SHALL cover: SRL by 31 with rst pulsed in the 10th shift cycle -> no out_valid, all outputs 0, in_ready=1 the cycle after rst falls.
REQ-037 SHALL cover: a WIDTH=8 instance, SLT, A=80, B=01 -> Y=01. Also XOR, A=A5, B=5A -> Y=FF, zero=0.
